// File: rtl/tlb_ctl_if.sv
// Bundle of TLB search, CP0 write/read, Wired/Random and invalidate signals.
// The controller takes the slave side; CP0 and the translation stages take the master side.
interface tlb_ctl_if #(parameter int TLBNUM = 16);
  localparam int IDXW = $clog2(TLBNUM);

  logic            s0_req, s1_req;
  logic [18:0]     s0_vpn2, s1_vpn2;
  logic            s0_odd_page, s1_odd_page;
  logic [7:0]      s0_asid, s1_asid;
  logic            s0_found, s1_found, s0_multi, s1_multi;
  logic [IDXW-1:0] s0_index, s1_index;
  logic [19:0]     s0_pfn, s1_pfn;
  logic [2:0]      s0_c, s1_c;
  logic            s0_d, s1_d, s0_v, s1_v;

  logic            we, w_random;
  logic [IDXW-1:0] w_index;
  logic [18:0]     w_vpn2;
  logic [7:0]      w_asid;
  logic            w_g;
  logic [19:0]     w_pfn0, w_pfn1;
  logic [2:0]      w_c0, w_c1;
  logic            w_d0, w_v0, w_d1, w_v1;

  logic [IDXW-1:0] r_index;
  logic            r_e;
  logic [18:0]     r_vpn2;
  logic [7:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_pfn0, r_pfn1;
  logic [2:0]      r_c0, r_c1;
  logic            r_d0, r_v0, r_d1, r_v1;

  logic            wired_we;
  logic [IDXW-1:0] wired_in, wired, random;

  logic            inv_req, inv_mode, inv_busy, inv_done;
  logic [7:0]      inv_asid;

  modport slave (
    input  s0_req, s0_vpn2, s0_odd_page, s0_asid, s1_req, s1_vpn2, s1_odd_page, s1_asid,
    output s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_found, s1_multi, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_random, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    output r_e, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    input  wired_we, wired_in,
    output wired, random,
    input  inv_req, inv_mode, inv_asid,
    output inv_busy, inv_done
  );

  modport master (
    output s0_req, s0_vpn2, s0_odd_page, s0_asid, s1_req, s1_vpn2, s1_odd_page, s1_asid,
    input  s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_found, s1_multi, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_random, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    input  r_e, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    output wired_we, wired_in,
    input  wired, random,
    output inv_req, inv_mode, inv_asid,
    input  inv_busy, inv_done
  );
endinterface

// File: rtl/tlb_ctl.sv
// Fully associative dual-page JTLB: two registered search ports, TLBWI/TLBWR write,
// combinational read, Random/Wired pair and a sequential invalidate walker.
module tlb_ctl #(
  parameter int TLBNUM = 16
) (
  input logic      clk,
  input logic      reset,
  tlb_ctl_if.slave bus
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

  logic [18:0] vpn2_mem [TLBNUM];
  logic [7:0]  asid_mem [TLBNUM];
  logic        g_mem    [TLBNUM];
  logic [19:0] pfn0_mem [TLBNUM];
  logic [2:0]  c0_mem   [TLBNUM];
  logic        d0_mem   [TLBNUM];
  logic        v0_mem   [TLBNUM];
  logic [19:0] pfn1_mem [TLBNUM];
  logic [2:0]  c1_mem   [TLBNUM];
  logic        d1_mem   [TLBNUM];
  logic        v1_mem   [TLBNUM];
  logic [TLBNUM-1:0] valid_reg;

  logic [IDXW-1:0] random_reg, wired_reg, w_target;

  typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} inv_state_t;
  inv_state_t      inv_state_reg;
  logic [IDXW-1:0] inv_ptr_reg;
  logic            inv_mode_reg, inv_busy_reg, inv_done_reg, inv_hit;
  logic [7:0]      inv_asid_reg;

  logic        s_req  [2];
  logic [18:0] s_vpn2 [2];
  logic        s_odd  [2];
  logic [7:0]  s_asid [2];

  assign s_req[0]  = bus.s0_req;       assign s_req[1]  = bus.s1_req;
  assign s_vpn2[0] = bus.s0_vpn2;      assign s_vpn2[1] = bus.s1_vpn2;
  assign s_odd[0]  = bus.s0_odd_page;  assign s_odd[1]  = bus.s1_odd_page;
  assign s_asid[0] = bus.s0_asid;      assign s_asid[1] = bus.s1_asid;

  genvar gp, gi;
  generate
    for (gp = 0; gp < 2; gp++) begin : g_port
      logic [TLBNUM-1:0] match;
      logic [IDXW-1:0]   hit_idx;
      logic              found_reg, multi_reg, d_reg, v_reg;
      logic [IDXW-1:0]   index_reg;
      logic [19:0]       pfn_reg;
      logic [2:0]        c_reg;

      for (gi = 0; gi < TLBNUM; gi++) begin : g_match
        assign match[gi] = valid_reg[gi] && (vpn2_mem[gi] == s_vpn2[gp]) &&
                           ((asid_mem[gi] == s_asid[gp]) || g_mem[gi]);
      end

      // Downward scan leaves the lowest matching index.
      always_comb begin
        hit_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
          if (match[i]) hit_idx = IDXW'(i);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          found_reg <= 1'b0;
          multi_reg <= 1'b0;
          index_reg <= '0;
          pfn_reg   <= '0;
          c_reg     <= '0;
          d_reg     <= 1'b0;
          v_reg     <= 1'b0;
        end else if (s_req[gp]) begin
          found_reg <= |match;
          multi_reg <= (match & (match - TLBNUM'(1))) != '0;
          index_reg <= hit_idx;
          if (|match) begin
            pfn_reg <= s_odd[gp] ? pfn1_mem[hit_idx] : pfn0_mem[hit_idx];
            c_reg   <= s_odd[gp] ? c1_mem[hit_idx]   : c0_mem[hit_idx];
            d_reg   <= s_odd[gp] ? d1_mem[hit_idx]   : d0_mem[hit_idx];
            v_reg   <= s_odd[gp] ? v1_mem[hit_idx]   : v0_mem[hit_idx];
          end else begin
            pfn_reg <= '0;
            c_reg   <= '0;
            d_reg   <= 1'b0;
            v_reg   <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign bus.s0_found = g_port[0].found_reg;  assign bus.s1_found = g_port[1].found_reg;
  assign bus.s0_multi = g_port[0].multi_reg;  assign bus.s1_multi = g_port[1].multi_reg;
  assign bus.s0_index = g_port[0].index_reg;  assign bus.s1_index = g_port[1].index_reg;
  assign bus.s0_pfn   = g_port[0].pfn_reg;    assign bus.s1_pfn   = g_port[1].pfn_reg;
  assign bus.s0_c     = g_port[0].c_reg;      assign bus.s1_c     = g_port[1].c_reg;
  assign bus.s0_d     = g_port[0].d_reg;      assign bus.s1_d     = g_port[1].d_reg;
  assign bus.s0_v     = g_port[0].v_reg;      assign bus.s1_v     = g_port[1].v_reg;

  assign w_target = bus.w_random ? random_reg : bus.w_index;

  // Entry payload is not reset; only the valid bits gate matching.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      vpn2_mem[w_target] <= bus.w_vpn2;
      asid_mem[w_target] <= bus.w_asid;
      g_mem[w_target]    <= bus.w_g;
      pfn0_mem[w_target] <= bus.w_pfn0;
      c0_mem[w_target]   <= bus.w_c0;
      d0_mem[w_target]   <= bus.w_d0;
      v0_mem[w_target]   <= bus.w_v0;
      pfn1_mem[w_target] <= bus.w_pfn1;
      c1_mem[w_target]   <= bus.w_c1;
      d1_mem[w_target]   <= bus.w_d1;
      v1_mem[w_target]   <= bus.w_v1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wired_reg  <= '0;
      random_reg <= LAST_IDX;
    end else if (bus.wired_we) begin
      wired_reg  <= bus.wired_in;
      random_reg <= LAST_IDX;
    end else if (random_reg <= wired_reg) begin
      random_reg <= LAST_IDX;
    end else begin
      random_reg <= random_reg - IDXW'(1);
    end
  end

  assign inv_hit = !inv_mode_reg ||
                   ((asid_mem[inv_ptr_reg] == inv_asid_reg) && !g_mem[inv_ptr_reg]);

  // Walker owns the valid bits; a same-edge write is applied last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_state_reg <= ST_IDLE;
      inv_ptr_reg   <= '0;
      inv_mode_reg  <= 1'b0;
      inv_asid_reg  <= '0;
      inv_busy_reg  <= 1'b0;
      inv_done_reg  <= 1'b0;
      valid_reg     <= '0;
    end else begin
      case (inv_state_reg)
        ST_IDLE: begin
          if (bus.inv_req) begin
            inv_mode_reg  <= bus.inv_mode;
            inv_asid_reg  <= bus.inv_asid;
            inv_ptr_reg   <= '0;
            inv_busy_reg  <= 1'b1;
            inv_state_reg <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (inv_hit) valid_reg[inv_ptr_reg] <= 1'b0;
          if (inv_ptr_reg == LAST_IDX) begin
            inv_state_reg <= ST_DONE;
            inv_done_reg  <= 1'b1;
          end else begin
            inv_ptr_reg <= inv_ptr_reg + IDXW'(1);
          end
        end
        ST_DONE: begin
          inv_state_reg <= ST_IDLE;
          inv_busy_reg  <= 1'b0;
          inv_done_reg  <= 1'b0;
        end
        default: inv_state_reg <= ST_IDLE;
      endcase
      if (bus.we) valid_reg[w_target] <= 1'b1;
    end
  end

  assign bus.inv_busy = inv_busy_reg;
  assign bus.inv_done = inv_done_reg;
  assign bus.wired    = wired_reg;
  assign bus.random   = random_reg;

  assign bus.r_e    = valid_reg[bus.r_index];
  assign bus.r_vpn2 = vpn2_mem[bus.r_index];
  assign bus.r_asid = asid_mem[bus.r_index];
  assign bus.r_g    = g_mem[bus.r_index];
  assign bus.r_pfn0 = pfn0_mem[bus.r_index];
  assign bus.r_c0   = c0_mem[bus.r_index];
  assign bus.r_d0   = d0_mem[bus.r_index];
  assign bus.r_v0   = v0_mem[bus.r_index];
  assign bus.r_pfn1 = pfn1_mem[bus.r_index];
  assign bus.r_c1   = c1_mem[bus.r_index];
  assign bus.r_d1   = d1_mem[bus.r_index];
  assign bus.r_v1   = v1_mem[bus.r_index];
endmodule

// File: doc/tlb_ctl.md
Name: tlb_ctl

Overview:
- Parametrised next-generation fully associative MIPS-style JTLB: TLBNUM dual-page entries, two search ports (fetch, data), one write port, one read port.
- Adds per-entry valid bits, registered search results (1-cycle latency) with multi-hit detection, a Random/Wired register pair for TLBWR, and a sequential invalidate walker for flush-all and ASID-flush.
- Sits between CP0 (TLBWI/TLBWR/TLBR/TLBP, Wired) and the IF/MEM address-translation stages.

Parameters:
- TLBNUM, 16, entry count; power of two, 2..64.
- IDXW, $clog2(TLBNUM), index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- s0_req  in  1  search request, port 0.
- s0_vpn2  in  19  VA[31:13].
- s0_odd_page  in  1  VA[12].
- s0_asid  in  8  current ASID.
- s0_found  out  1  registered: exactly one or more valid matches.
- s0_multi  out  1  registered: more than one valid match.
- s0_index  out  IDXW  registered: lowest matching index.
- s0_pfn  out  20  registered page frame number, selected page.
- s0_c  out  3  registered cache attribute.
- s0_d  out  1  registered dirty bit.
- s0_v  out  1  registered valid bit.
- s1_*  same set as s0_*, port 1.
- we  in  1  write strobe.
- w_random  in  1  1: write at random index (TLBWR); 0: write at w_index (TLBWI).
- w_index  in  IDXW  write index.
- w_vpn2 19, w_asid 8, w_g 1, w_pfn0 20, w_c0 3, w_d0 1, w_v0 1, w_pfn1 20, w_c1 3, w_d1 1, w_v1 1  in  entry fields.
- r_index  in  IDXW  read index.
- r_e  out  1  combinational: entry valid bit.
- r_vpn2/r_asid/r_g/r_pfn0/r_c0/r_d0/r_v0/r_pfn1/r_c1/r_d1/r_v1  out  as w_*  combinational entry fields.
- wired_we  in  1  Wired write strobe.
- wired_in  in  IDXW  new Wired value.
- wired  out  IDXW  Wired register.
- random  out  IDXW  Random register.
- inv_req  in  1  start invalidate walk.
- inv_mode  in  1  0: invalidate all; 1: invalidate entries with asid == inv_asid and g == 0.
- inv_asid  in  8  ASID for mode 1.
- inv_busy  out  1  walk in progress.
- inv_done  out  1  1-cycle pulse when walk ends.

Behaviour:
- Reset (sync, high):
  - all entry valid bits = 0; wired = 0; random = TLBNUM-1.
  - all s*_ outputs = 0; inv_busy = 0; inv_done = 0; walker state IDLE.
  - Entry field contents are not cleared.
- Match[i] = valid[i] && vpn2 equal && (asid equal || g[i]).
- Search:
  - On posedge with sN_req = 1, the outputs register found, multi, lowest-index match, and odd/even page fields.
  - With sN_req = 0, the outputs hold.
  - No match: found = 0, multi = 0, index = 0, pfn/c/d/v = 0.
  - Latency is exactly 1 cycle; a search coincident with a write samples pre-write contents.
- Write:
  - On posedge with we = 1, the entry at the target index takes all w_* fields and valid = 1.
  - Target index = w_random ? random : w_index.
- Random:
  - Decrements each cycle.
  - When random <= wired, next value is TLBNUM-1.
  - wired_we sets wired = wired_in and random = TLBNUM-1 in the same edge; this has priority over decrement.
  - wired_in >= TLBNUM-1 holds random at TLBNUM-1.
- Invalidate walker, states IDLE -> WALK -> DONE -> IDLE:
  - IDLE: inv_req latches mode/asid, ptr = 0, next state WALK.
  - WALK: one entry per cycle, clearing valid[ptr] if the mode condition holds. At ptr = TLBNUM-1, next state is DONE.
  - DONE: inv_done = 1 for one cycle, then IDLE.
  - inv_busy = 1 in WALK and DONE.
  - inv_req while busy is ignored.
  - Write to ptr entry in the same cycle: the write wins (valid = 1).
  - Searches and reads remain legal during the walk and see current state.
  - reset mid-walk: IDLE immediately, no inv_done.
- Read port is purely combinational from the current array.

Test Plan:
- Reset, then search vpn2=0x00000, asid=0 -> s0_found=0 next cycle; random=TLBNUM-1 (15); all valid=0.
- we at index 3: vpn2=0x12345, asid=5, g=0, pfn1=0xABCDE, v1=1, d1=1; next cycle s1 search vpn2=0x12345, odd=1, asid=5 -> s1_found=1, s1_index=3, s1_pfn=0xABCDE, s1_v=1, s1_d=1. Same search with asid=6 -> found=0. Rewrite with g=1 and repeat asid=6 -> found=1.
- Write identical vpn2/asid at indices 2 and 9 -> s0_found=1, s0_multi=1, s0_index=2.
- wired_we with wired_in=4 -> random=15, then 14 .. 4, then 15. we with w_random=1 when random=7 -> entry 7 written; r_index=7 returns its fields and r_e=1.
- Valid entries 1 (asid 5, g=0), 2 (asid 5, g=1), 3 (asid 6, g=0); inv_req, inv_mode=1, inv_asid=5 -> inv_busy for 17 cycles (TLBNUM+1), inv_done pulse; only entry 1 invalid afterwards. Repeat with a TLBWI to entry 4 in the cycle ptr=4 -> entry 4 valid.
- Assert reset at ptr=8 of a mode-0 walk -> inv_busy=0 next cycle, no inv_done, all valid=0, wired=0.
